spi_slave_core: RTL and testbench
=================================

Name: spi_slave_core

Overview:
Parametrised successor to the fixed-mode 8-bit SPI slave. It oversamples SCLK, CS_N and MOSI in the system clock domain and supports a runtime-selectable SPI mode, latched per frame. Word width and bit order are parameters, and multi-word bursts run within one chip-select frame. It has valid/ready handshakes on both data sides, plus underrun and aborted-frame reporting. It sits between the pad-level SPI wires and the register/command layer.

Parameters:
DATA_W, 8, bits per SPI word (4..32)
LSB_FIRST, 0, 1 = shift LSB first on both MOSI and MISO
SYNC_STAGES, 2, synchroniser depth on spi_sclk/spi_cs_n/spi_mosi (>=2)
IDLE_FILL, all-ones, MISO word transmitted on underrun (DATA_W bits)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
cfg_mode  in  2  {CPOL,CPHA}; sampled on CS_N falling detect
spi_cs_n  in  1  chip select, active low, asynchronous
spi_sclk  in  1  SPI clock, asynchronous
spi_mosi  in  1  master-out data
spi_miso  out  1  slave-out data
spi_miso_oe  out  1  MISO output enable (high while frame active)
tx_data  in  DATA_W  next word to transmit
tx_valid  in  1  tx_data valid
tx_ready  out  1  one-cycle pulse; tx_data consumed this cycle when tx_valid=1
rx_data  out  DATA_W  last complete received word
rx_valid  out  1  one-cycle pulse, rx_data updated
busy  out  1  frame active
underrun  out  1  one-cycle pulse: word load with tx_valid=0, IDLE_FILL sent
frame_err  out  1  one-cycle pulse: CS_N deasserted with partial word (bit count != 0)

Behaviour:
- Reset: spi_miso=0, spi_miso_oe=0, tx_ready=0, rx_data=0, rx_valid=0, busy=0, underrun=0, frame_err=0; FSM=IDLE, bit counter=0, latched mode=0.
- Inputs pass through SYNC_STAGES flops. Edges are detected on the synchronised sclk (previous vs current). Timing requirement: each SCLK half-period >= SYNC_STAGES+2 clk.
- Leading edge = sclk leaving CPOL level; trailing = returning to it. CPHA=0: sample on leading, shift on trailing. CPHA=1: shift on leading, sample on trailing.
- FSM states: IDLE, LOAD, SHIFT.
- IDLE: on synchronised CS_N falling -> latch cfg_mode, busy=1, miso_oe=1 -> LOAD.
- LOAD (one cycle): tx_ready=1. If tx_valid, shift_tx<=tx_data, else shift_tx<=IDLE_FILL and underrun=1. Bit counter=0 -> SHIFT. The first bit is on spi_miso the cycle after LOAD. For CPHA=0 the first bit is therefore present before the first leading edge, given the timing requirement.
- SHIFT, sample event: shift_rx takes mosi at MSB or LSB end per LSB_FIRST; counter++.
  - When counter reaches DATA_W: rx_data<=assembled word, rx_valid pulse next cycle.
- SHIFT, shift event: spi_miso advances to the next bit.
  - CPHA=0: no shift on the trailing edge after bit DATA_W-1; go to LOAD instead, so the next word's first bit is presented.
  - CPHA=1: the first leading edge of each word presents bit 0. LOAD happens when the counter reaches DATA_W, before the next leading edge.
- Latched mode is ignored mid-frame. cfg_mode changes take effect on the next frame only.
- CS_N rising detect in any state -> IDLE, busy=0, miso_oe=0, spi_miso=0, counter=0.
  - If the counter is nonzero and not DATA_W: frame_err pulse, no rx_valid, partial word discarded.
  - If the final word completed the same cycle CS rises: rx_valid still fires, no frame_err.
- Sample and CS-rise in the same cycle: the sample is applied first, then the abort is evaluated.
- An edge seen while in IDLE or LOAD is ignored. CS falling while busy cannot occur, since CS rise forces IDLE first.
- Counter width: clog2(DATA_W+1). No wrap; it is cleared in LOAD.
- rst asserted mid-frame: immediate return to the reset state; the frame resumes only after a fresh CS_N falling edge.

Decomposition:
- Shared package spi_pkg holds the mode encoding constants (MODE0..MODE3, CPOL/CPHA bit indices) and the FSM state enum.
- One natural sub-module: spi_sync_edge, the N-stage synchroniser plus rise/fall detect, instantiated for sclk and cs_n. mosi uses the synchroniser only.
- Shift/count/FSM remain in the top.

Test Plan:
- Mode 0, DATA_W=8, MSB-first, tx_data=0xA5 valid, master sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1; rx_data=0x3C with a single rx_valid pulse; no err.
- Mode 3 with LSB_FIRST=1, two words in one frame (tx 0x12 then 0x34, master 0x81,0x7E) -> two tx_ready, two rx_valid, rx 0x81 then 0x7E, MISO LSB-first.
- tx_valid=0 at LOAD in mode 1 -> underrun pulse, MISO sends 0xFF, rx path unaffected.
- CS_N raised after 5 bits in mode 2 -> frame_err pulse, no rx_valid, miso_oe=0, busy=0; next frame received correctly.
- cfg_mode changed mid-frame (0->1) -> current frame stays mode 0; next frame decodes in mode 1.
- rst held 1 cycle mid-word, DATA_W=16 -> all outputs at reset values; a new frame with 0xBEEF is received correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants for the SPI slave: mode encoding, CPOL/CPHA bit positions
// and the frame FSM state codes.
package spi_pkg;

    localparam int CPOL_IDX = 1;
    localparam int CPHA_IDX = 0;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_LOAD  = 2'd1;
    localparam state_t ST_SHIFT = 2'd2;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser for an asynchronous pad input, with rise/fall detection
// on the synchronised level.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_r;
    logic              prev_r;

    // Synchroniser chain plus one-cycle history of the synchronised level
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= '0;
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], din};
            prev_r <= sync_r[STAGES-1];
        end
    end

    assign rise = sync_r[STAGES-1] & ~prev_r;
    assign fall = ~sync_r[STAGES-1] & prev_r;

endmodule

// File: rtl/spi_slave_core.sv
// Oversampled SPI slave: per-frame latched mode, parametrised word width and
// bit order, multi-word bursts, underrun and aborted-frame reporting.
module spi_slave_core
    import spi_pkg::*;
#(
    parameter int              DATA_W      = 8,
    parameter int              LSB_FIRST   = 0,
    parameter int              SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] IDLE_FILL = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        cfg_mode,
    input  logic              spi_cs_n,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              underrun,
    output logic              frame_err
);

    localparam int              CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic sclk_rise_s, sclk_fall_s, cs_rise_s, cs_fall_s;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic mosi_s;

    state_t            state_r, state_next_s;
    logic [1:0]        mode_r;
    logic [CNT_W-1:0]  cnt_r, cnt_next_s;
    logic [DATA_W-1:0] shift_tx_r, tx_shifted_s, load_word_s;
    logic [DATA_W-2:0] shift_rx_r, rx_keep_s;
    logic [DATA_W-1:0] rx_word_s;
    logic              presented_r;
    logic              leading_s, trailing_s, sample_s, shift_s;
    logic              word_done_s, abort_err_s, tx_next_bit_s, load_bit_s;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (spi_sclk),
        .rise (sclk_rise_s),
        .fall (sclk_fall_s)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (spi_cs_n),
        .rise (cs_rise_s),
        .fall (cs_fall_s)
    );

    // MOSI needs only the level, delayed to match the SCLK edge detect path
    always_ff @(posedge clk) begin
        if (rst) begin
            mosi_sync_r <= '0;
        end else begin
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi_mosi};
        end
    end

    assign mosi_s = mosi_sync_r[SYNC_STAGES-1];

    // Bit-order dependent datapath views of the shift registers
    always_comb begin
        load_word_s = tx_valid ? tx_data : IDLE_FILL;
        if (LSB_FIRST != 0) begin
            rx_word_s     = {mosi_s, shift_rx_r};
            rx_keep_s     = rx_word_s[DATA_W-1:1];
            tx_shifted_s  = shift_tx_r >> 1'b1;
            tx_next_bit_s = shift_tx_r[1];
            load_bit_s    = load_word_s[0];
        end else begin
            rx_word_s     = {shift_rx_r, mosi_s};
            rx_keep_s     = rx_word_s[DATA_W-2:0];
            tx_shifted_s  = shift_tx_r << 1'b1;
            tx_next_bit_s = shift_tx_r[DATA_W-2];
            load_bit_s    = load_word_s[DATA_W-1];
        end
    end

    // Edge classification from the latched mode, counter and next-state logic
    always_comb begin
        if (mode_r[CPOL_IDX]) begin
            leading_s  = sclk_fall_s;
            trailing_s = sclk_rise_s;
        end else begin
            leading_s  = sclk_rise_s;
            trailing_s = sclk_fall_s;
        end
        sample_s = (state_r == ST_SHIFT) && (cnt_r != CNT_FULL) &&
                   (mode_r[CPHA_IDX] ? trailing_s : leading_s);
        shift_s  = (state_r == ST_SHIFT) && (cnt_r != CNT_FULL) &&
                   (mode_r[CPHA_IDX] ? leading_s : trailing_s);
        cnt_next_s  = sample_s ? (cnt_r + CNT_ONE) : cnt_r;
        word_done_s = sample_s && (cnt_next_s == CNT_FULL);
        // Abort is judged after any same-cycle sample has been counted
        abort_err_s = cs_rise_s && (cnt_next_s != '0) && (cnt_next_s != CNT_FULL);

        case (state_r)
            ST_IDLE: begin
                state_next_s = cs_fall_s ? ST_LOAD : ST_IDLE;
            end
            ST_LOAD: begin
                state_next_s = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (cnt_r != CNT_FULL) begin
                    state_next_s = ST_SHIFT;
                end else if (mode_r[CPHA_IDX]) begin
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = (mode_r[CPOL_IDX] ? sclk_rise_s : sclk_fall_s) ?
                                   ST_LOAD : ST_SHIFT;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
        if (cs_rise_s) begin
            state_next_s = ST_IDLE;
        end else begin
            state_next_s = state_next_s;
        end
    end

    // Frame FSM, shift registers and registered status/handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            mode_r      <= 2'b00;
            cnt_r       <= '0;
            shift_tx_r  <= '0;
            shift_rx_r  <= '0;
            presented_r <= 1'b0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            tx_ready    <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            busy        <= 1'b0;
            underrun    <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            tx_ready  <= (state_next_s == ST_LOAD);
            rx_valid  <= 1'b0;
            underrun  <= 1'b0;
            frame_err <= 1'b0;

            if (sample_s) begin
                shift_rx_r <= rx_keep_s;
                cnt_r      <= cnt_next_s;
            end
            if (word_done_s) begin
                rx_data  <= rx_word_s;
                rx_valid <= 1'b1;
            end

            case (state_r)
                ST_IDLE: begin
                    if (cs_fall_s) begin
                        mode_r      <= cfg_mode;
                        busy        <= 1'b1;
                        spi_miso_oe <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    shift_tx_r  <= load_word_s;
                    spi_miso    <= load_bit_s;
                    underrun    <= ~tx_valid;
                    cnt_r       <= '0;
                    // With CPHA=1 the first leading edge re-presents bit 0
                    presented_r <= ~mode_r[CPHA_IDX];
                end
                ST_SHIFT: begin
                    if (shift_s && presented_r) begin
                        shift_tx_r <= tx_shifted_s;
                        spi_miso   <= tx_next_bit_s;
                    end else if (shift_s) begin
                        presented_r <= 1'b1;
                    end
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase

            if (cs_rise_s) begin
                busy        <= 1'b0;
                spi_miso_oe <= 1'b0;
                spi_miso    <= 1'b0;
                cnt_r       <= '0;
                frame_err   <= abort_err_s;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core: three instances (8-bit MSB-first,
// 8-bit LSB-first, 16-bit MSB-first) driven by a bit-banged SPI master.
module tb_spi_slave_core;

    localparam int H = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cfg_mode;
    logic [2:0]  cs_n;
    logic        sclk, mosi;
    logic [15:0] tx_data_bus = 16'h0000;
    logic        tx_valid_bus = 1'b0;
    logic [2:0]  miso, oe, tx_ready, rx_valid, busy, underrun, frame_err;
    logic [7:0]  rx0, rx1;
    logic [15:0] rx2;

    int cnt_cmp = 0;
    int cnt_bad = 0;
    int n_ready = 0, n_unr = 0, n_ferr = 0;
    int b_ready = 0, b_unr = 0, b_ferr = 0;
    bit pop_pend = 1'b0;

    logic [15:0] src_q[$];
    logic [15:0] exp_miso[$];
    logic [17:0] exp_rx[$];

    always #5 clk = ~clk;

    spi_slave_core #(.DATA_W(8), .LSB_FIRST(0), .SYNC_STAGES(2), .IDLE_FILL(8'hFF)) u0 (
        .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .spi_cs_n(cs_n[0]), .spi_sclk(sclk),
        .spi_mosi(mosi), .spi_miso(miso[0]), .spi_miso_oe(oe[0]), .tx_data(tx_data_bus[7:0]),
        .tx_valid(tx_valid_bus), .tx_ready(tx_ready[0]), .rx_data(rx0), .rx_valid(rx_valid[0]),
        .busy(busy[0]), .underrun(underrun[0]), .frame_err(frame_err[0]));

    spi_slave_core #(.DATA_W(8), .LSB_FIRST(1), .SYNC_STAGES(2), .IDLE_FILL(8'hFF)) u1 (
        .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .spi_cs_n(cs_n[1]), .spi_sclk(sclk),
        .spi_mosi(mosi), .spi_miso(miso[1]), .spi_miso_oe(oe[1]), .tx_data(tx_data_bus[7:0]),
        .tx_valid(tx_valid_bus), .tx_ready(tx_ready[1]), .rx_data(rx1), .rx_valid(rx_valid[1]),
        .busy(busy[1]), .underrun(underrun[1]), .frame_err(frame_err[1]));

    spi_slave_core #(.DATA_W(16), .LSB_FIRST(0), .SYNC_STAGES(2), .IDLE_FILL(16'hFFFF)) u2 (
        .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .spi_cs_n(cs_n[2]), .spi_sclk(sclk),
        .spi_mosi(mosi), .spi_miso(miso[2]), .spi_miso_oe(oe[2]), .tx_data(tx_data_bus),
        .tx_valid(tx_valid_bus), .tx_ready(tx_ready[2]), .rx_data(rx2), .rx_valid(rx_valid[2]),
        .busy(busy[2]), .underrun(underrun[2]), .frame_err(frame_err[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cnt_cmp++;
        assert (obs === exp) else begin
            cnt_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clk_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: pulse counting, rx scoreboard, and the tx word feeder
    always @(negedge clk) begin
        logic [17:0] got, exp;
        n_ready += $countones(tx_ready);
        n_unr   += $countones(underrun);
        n_ferr  += $countones(frame_err);
        for (int i = 0; i < 3; i++) begin
            if (rx_valid[i]) begin
                got = (i == 0) ? {2'd0, 8'h00, rx0} : (i == 1) ? {2'd1, 8'h00, rx1} : {2'd2, rx2};
                exp = (exp_rx.size() > 0) ? exp_rx.pop_front() : 18'h3FFFF;
                chk("rx_word", {14'h0, got}, {14'h0, exp});
            end
        end
        if (pop_pend && src_q.size() > 0) void'(src_q.pop_front());
        pop_pend     = (|tx_ready) && tx_valid_bus;
        tx_valid_bus = (src_q.size() > 0);
        tx_data_bus  = (src_q.size() > 0) ? src_q[0] : 16'h0000;
    end

    task automatic xfer(input int id, input logic [1:0] mode, input logic [1:0] mode_mid,
                        input int nw, input logic [15:0] m0, input logic [15:0] m1,
                        input int nbits, input int rst_at);
        int w, idx;
        bit lsb, cpol, cpha, done;
        logic [15:0] mw, got, expm;
        w = (id == 2) ? 16 : 8;
        lsb = (id == 1);
        cpol = mode[1];
        cpha = mode[0];
        cfg_mode = mode;
        sclk = cpol;
        clk_wait(H);
        cs_n[id] = 1'b0;
        clk_wait(H);
        done = 1'b0;
        for (int k = 0; k < nw && !done; k++) begin
            mw = (k == 0) ? m0 : m1;
            got = 16'h0000;
            for (int b = 0; b < w; b++) begin
                if (k == 0 && b == nbits) begin
                    done = 1'b1;
                    break;
                end
                if (rst_at > 0 && b == rst_at) begin
                    rst = 1'b1;
                    clk_wait(1);
                    chk("rst_outputs", {25'h0, miso[id], oe[id], tx_ready[id], rx_valid[id],
                                        busy[id], underrun[id], frame_err[id]}, 32'h0);
                    chk("rst_rx_data", {16'h0, rx2}, 32'h0);
                    rst = 1'b0;
                    done = 1'b1;
                    break;
                end
                if (k == 0 && b == 0) chk("busy_oe", {30'h0, busy[id], oe[id]}, 32'h3);
                idx = lsb ? b : (w - 1 - b);
                if (!cpha) begin
                    mosi = mw[idx];
                    clk_wait(H);
                    got[idx] = miso[id];
                    sclk = ~cpol;
                    clk_wait(H);
                    sclk = cpol;
                end else begin
                    sclk = ~cpol;
                    mosi = mw[idx];
                    clk_wait(H);
                    got[idx] = miso[id];
                    sclk = cpol;
                    clk_wait(H);
                end
                if (k == 0 && b == 0) cfg_mode = mode_mid;
            end
            expm = (exp_miso.size() > 0) ? exp_miso.pop_front() : 16'hDEAD;
            if (!done) chk("miso_word", {16'h0, got}, {16'h0, expm});
        end
        clk_wait(H);
        cs_n[id] = 1'b1;
        clk_wait(2 * H);
    endtask

    task automatic post(input string tag, input int dr, input int du, input int df);
        chk({tag, "_ready"}, n_ready - b_ready, dr);
        chk({tag, "_underrun"}, n_unr - b_unr, du);
        chk({tag, "_frame_err"}, n_ferr - b_ferr, df);
        chk({tag, "_idle"}, {23'h0, busy, oe, miso}, 32'h0);
        chk({tag, "_rx_pending"}, exp_rx.size(), 0);
        b_ready = n_ready;
        b_unr   = n_unr;
        b_ferr  = n_ferr;
    endtask

    initial begin
        rst = 1'b1;
        cfg_mode = 2'b00;
        cs_n = 3'b111;
        sclk = 1'b0;
        mosi = 1'b0;
        clk_wait(3);
        chk("reset_flags", {11'h0, miso, oe, tx_ready, rx_valid, busy, underrun, frame_err}, 32'h0);
        chk("reset_rx", {rx2, rx1, rx0}, 32'h0);
        rst = 1'b0;
        clk_wait(6);
        b_ready = n_ready; b_unr = n_unr; b_ferr = n_ferr;

        // Mode 0, MSB-first: tx A5, master sends 3C; trailing LOAD underruns
        src_q.push_back(16'h00A5); exp_miso.push_back(16'h00A5); exp_rx.push_back({2'd0, 16'h003C});
        xfer(0, 2'b00, 2'b00, 1, 16'h003C, 16'h0000, 99, 0);
        post("mode0", 2, 1, 0);

        // Mode 3, LSB-first, two-word burst
        src_q.push_back(16'h0012); src_q.push_back(16'h0034);
        exp_miso.push_back(16'h0012); exp_miso.push_back(16'h0034);
        exp_rx.push_back({2'd1, 16'h0081}); exp_rx.push_back({2'd1, 16'h007E});
        xfer(1, 2'b11, 2'b11, 2, 16'h0081, 16'h007E, 99, 0);
        post("mode3_burst", 3, 1, 0);

        // Mode 1 with nothing to send: IDLE_FILL on MISO
        exp_miso.push_back(16'h00FF); exp_rx.push_back({2'd0, 16'h00C9});
        xfer(0, 2'b01, 2'b01, 1, 16'h00C9, 16'h0000, 99, 0);
        post("underrun", 2, 2, 0);

        // Mode 2 aborted after 5 bits, then a clean frame
        src_q.push_back(16'h005A); exp_miso.push_back(16'h005A);
        xfer(0, 2'b10, 2'b10, 1, 16'h00E7, 16'h0000, 5, 0);
        post("abort", 1, 0, 1);
        src_q.push_back(16'h00C3); exp_miso.push_back(16'h00C3); exp_rx.push_back({2'd0, 16'h0096});
        xfer(0, 2'b10, 2'b10, 1, 16'h0096, 16'h0000, 99, 0);
        post("after_abort", 2, 1, 0);

        // cfg_mode switched to 1 mid-frame; takes effect next frame
        src_q.push_back(16'h000F); exp_miso.push_back(16'h000F); exp_rx.push_back({2'd0, 16'h00F0});
        xfer(0, 2'b00, 2'b01, 1, 16'h00F0, 16'h0000, 99, 0);
        post("mode_hold", 2, 1, 0);
        src_q.push_back(16'h0011); exp_miso.push_back(16'h0011); exp_rx.push_back({2'd0, 16'h0022});
        xfer(0, 2'b01, 2'b01, 1, 16'h0022, 16'h0000, 99, 0);
        post("mode_next", 2, 1, 0);

        // 16-bit: reset mid-word, then a fresh frame receiving BEEF
        src_q.push_back(16'h1234); exp_miso.push_back(16'h1234);
        xfer(2, 2'b00, 2'b00, 1, 16'hCAFE, 16'h0000, 99, 6);
        post("rst_mid", 1, 0, 0);
        src_q.push_back(16'h5AA5); exp_miso.push_back(16'h5AA5); exp_rx.push_back({2'd2, 16'hBEEF});
        xfer(2, 2'b00, 2'b00, 1, 16'hBEEF, 16'h0000, 99, 0);
        post("after_rst", 2, 1, 0);

        chk("miso_queue_left", exp_miso.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt_cmp, cnt_bad);
        $finish;
    end

endmodule
